// File: rtl/abr_params_pkg.sv
// Shared arithmetic parameters for the ML-DSA datapath: modulus and coefficient register width.
package abr_params_pkg;

    localparam int REG_SIZE = 24;
    localparam int MLDSA_Q  = 8380417;

endpackage

// File: rtl/skdecode_defines_pkg.sv
// Secret-key decode constants shared by the t0 unpack path: field width, encoding offset and range,
// and the unpack progress states.
package skdecode_defines_pkg;

    localparam int T0_COEFF_W    = 13;
    localparam int T0_ENC_OFFSET = 4096;
    localparam int T0_ENC_MAX    = 8190;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DRAIN  = 2'd2
    } t0_unpack_state_e;

endpackage

// File: rtl/skdecode_t0_map.sv
// Combinational t0 field to coefficient mapping: coeff = (4096 - v) mod q, zero-extended to REG_SIZE.
module skdecode_t0_map
    import abr_params_pkg::*;
    import skdecode_defines_pkg::*;
(
    input  logic [T0_COEFF_W-1:0] field_i,
    output logic [REG_SIZE-1:0]   coeff_o
);

    localparam logic [REG_SIZE-1:0] OFFSET        = REG_SIZE'(T0_ENC_OFFSET);
    localparam logic [REG_SIZE-1:0] Q_PLUS_OFFSET = REG_SIZE'(MLDSA_Q + T0_ENC_OFFSET);

    logic [REG_SIZE-1:0] field_ext;

    // Values above the offset wrap through q so the result stays in [0, q).
    always_comb begin
        field_ext = REG_SIZE'(field_i);
        if (field_ext <= OFFSET) begin
            coeff_o = OFFSET - field_ext;
        end else begin
            coeff_o = Q_PLUS_OFFSET - field_ext;
        end
    end

endmodule

// File: rtl/skdecode_t0_unpack.sv
// t0 unpack stage: bit buffer fed by 64-bit key reads, emits four mapped coefficients per extract.
// Optional sticky encoding-error flag is built only when ABR_SKDEC_T0_ERR_CHECK_EN is defined.
module skdecode_t0_unpack
    import abr_params_pkg::*;
    import skdecode_defines_pkg::*;
#(
    parameter int IN_W      = 64,
    parameter int COEFF_W   = T0_COEFF_W,
    parameter int NUM_COEFF = 4,
    parameter int BUF_W     = 192
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          zeroize,
    input  logic                          enable,
    input  logic [IN_W-1:0]               data_i,
    input  logic                          data_valid_i,
    output logic [NUM_COEFF*REG_SIZE-1:0] data_o,
    output logic                          valid_o,
    output logic                          buf_full_o,
    output logic                          error_o
);

    localparam int OUT_W       = NUM_COEFF * COEFF_W;
    localparam int CNT_W       = $clog2(BUF_W + 1);
    localparam int FULL_THRESH = BUF_W - 2 * IN_W + OUT_W;

    logic [BUF_W-1:0]              buf_q, buf_d;
    logic [CNT_W-1:0]              count_q, count_d;
    logic                          enable_q;
    t0_unpack_state_e              state_q, state_d;
    logic [NUM_COEFF*REG_SIZE-1:0] data_q;
    logic                          valid_q;

    logic                          en_rise;
    logic                          extract;
    logic                          accept;
    logic                          overflow;
    logic [BUF_W-1:0]              buf_kept;
    logic [CNT_W-1:0]              count_kept;
    logic [CNT_W:0]                count_room;
    logic [OUT_W-1:0]              slice;
    logic [NUM_COEFF*REG_SIZE-1:0] coeffs;

    assign en_rise = enable & ~enable_q;
    // A new key discards whatever is in the buffer, so nothing is sliced on that cycle.
    assign extract = (count_q >= CNT_W'(OUT_W)) & ~en_rise;
    assign slice   = buf_q[OUT_W-1:0];

    // Remove the extracted slice first, then append the incoming beat above what remains.
    always_comb begin
        buf_kept   = buf_q;
        count_kept = count_q;
        if (en_rise) begin
            buf_kept   = '0;
            count_kept = '0;
        end else if (extract) begin
            buf_kept   = buf_q >> OUT_W;
            count_kept = count_q - CNT_W'(OUT_W);
        end

        count_room = {1'b0, count_kept} + (CNT_W + 1)'(IN_W);
        overflow   = count_room > (CNT_W + 1)'(BUF_W);
        accept     = data_valid_i & ~overflow;

        buf_d   = buf_kept;
        count_d = count_kept;
        if (accept) begin
            buf_d   = buf_kept | (BUF_W'(data_i) << count_kept);
            count_d = count_room[CNT_W-1:0];
        end
    end

    for (genvar i = 0; i < NUM_COEFF; i++) begin : g_map
        skdecode_t0_map u_map (
            .field_i (slice[i*COEFF_W +: COEFF_W]),
            .coeff_o (coeffs[i*REG_SIZE +: REG_SIZE])
        );
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (en_rise) state_d = ACTIVE;
            end
            ACTIVE: begin
                if (!enable) state_d = DRAIN;
            end
            DRAIN: begin
                if (en_rise) begin
                    state_d = ACTIVE;
                end else if (!extract && (count_q < CNT_W'(OUT_W))) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            buf_q    <= '0;
            count_q  <= '0;
            enable_q <= 1'b0;
            state_q  <= IDLE;
            data_q   <= '0;
            valid_q  <= 1'b0;
        end else if (zeroize) begin
            buf_q    <= '0;
            count_q  <= '0;
            enable_q <= 1'b0;
            state_q  <= IDLE;
            data_q   <= '0;
            valid_q  <= 1'b0;
        end else begin
            buf_q    <= buf_d;
            count_q  <= count_d;
            enable_q <= enable;
            state_q  <= state_d;
            valid_q  <= extract;
            if (extract) data_q <= coeffs;
        end
    end

    assign data_o     = data_q;
    assign valid_o    = valid_q;
    assign buf_full_o = count_q > CNT_W'(FULL_THRESH);

`ifdef ABR_SKDEC_T0_ERR_CHECK_EN
    logic error_q, error_d;
    logic field_bad;

    always_comb begin
        field_bad = 1'b0;
        for (int i = 0; i < NUM_COEFF; i++) begin
            if (slice[i*COEFF_W +: COEFF_W] > COEFF_W'(T0_ENC_MAX)) field_bad = 1'b1;
        end
        error_d = en_rise ? 1'b0 : (error_q | (extract & field_bad));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            error_q <= 1'b0;
        end else if (zeroize) begin
            error_q <= 1'b0;
        end else begin
            error_q <= error_d;
        end
    end

    assign error_o = error_q;
`else
    assign error_o = 1'b0;
`endif

`ifndef SYNTHESIS
    // The full threshold leaves room for exactly one in-flight beat; anything more is dropped.
    always @(posedge clk) begin
        if (reset_n && !zeroize) begin
            assert (!(data_valid_i && overflow))
                else $error("skdecode_t0_unpack: beat dropped, buffer overflow");
        end
    end
`endif

endmodule

// File: tb/tb_skdecode_t0_unpack.sv
// Bench for skdecode_t0_unpack: bit-queue reference model, per-cycle compare, directed literal pins.
`timescale 1ns/1ps
module tb_skdecode_t0_unpack;
    import abr_params_pkg::*;
    import skdecode_defines_pkg::*;

    localparam int IN_W       = 64;
    localparam int NUM_COEFF  = 4;
    localparam int FIELD_W    = 13;
    localparam int OUT_W      = 52;
    localparam int BUF_W      = 192;
    localparam int FULL_LIMIT = 116;
    localparam int DW         = NUM_COEFF * REG_SIZE;
    localparam int KEY_BEATS  = 416;

`ifdef ABR_SKDEC_T0_ERR_CHECK_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic            zeroize = 1'b0;
    logic            enable = 1'b0;
    logic [IN_W-1:0] data_i = '0;
    logic            data_valid_i = 1'b0;
    logic [DW-1:0]   data_o;
    logic            valid_o;
    logic            buf_full_o;
    logic            error_o;

    always #5 clk = ~clk;

    skdecode_t0_unpack dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .zeroize      (zeroize),
        .enable       (enable),
        .data_i       (data_i),
        .data_valid_i (data_valid_i),
        .data_o       (data_o),
        .valid_o      (valid_o),
        .buf_full_o   (buf_full_o),
        .error_o      (error_o)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int pulse_cnt = 0;
    bit chk_on = 1'b0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // The buffer is a plain queue of bits, oldest first; coefficients use the field formula directly.
    bit               mq[$];
    logic [DW-1:0]    exp_q[$];
    bit               exp_valid;
    bit               exp_err;
    bit               prev_en;
    t0_unpack_state_e exp_state;

    always @(posedge clk or negedge reset_n) begin
        bit            rise;
        int            sz;
        int            v;
        bit            bad;
        logic [DW-1:0] beat;
        if (!reset_n || zeroize) begin
            mq.delete();
            exp_q.delete();
            exp_valid = 1'b0;
            exp_err   = 1'b0;
            prev_en   = 1'b0;
            exp_state = IDLE;
        end else begin
            rise = enable && !prev_en;
            sz   = mq.size();
            case (exp_state)
                IDLE:    if (rise) exp_state = ACTIVE;
                ACTIVE:  if (!enable) exp_state = DRAIN;
                DRAIN:   if (rise) exp_state = ACTIVE; else if (sz < OUT_W) exp_state = IDLE;
                default: exp_state = IDLE;
            endcase
            exp_valid = 1'b0;
            if (rise) begin
                mq.delete();
                exp_err = 1'b0;
            end else if (sz >= OUT_W) begin
                beat = '0;
                bad  = 1'b0;
                for (int f = 0; f < NUM_COEFF; f++) begin
                    v = 0;
                    for (int b = 0; b < FIELD_W; b++) v = v | (int'(mq.pop_front()) << b);
                    if (v > 8190) bad = 1'b1;
                    beat[f*REG_SIZE +: REG_SIZE] =
                        REG_SIZE'((v <= 4096) ? (4096 - v) : (MLDSA_Q + 4096 - v));
                end
                exp_q.push_back(beat);
                exp_valid = 1'b1;
                exp_err   = exp_err | (bad & ERR_EN);
            end
            if (data_valid_i && (mq.size() + IN_W <= BUF_W)) begin
                for (int i = 0; i < IN_W; i++) mq.push_back(data_i[i]);
            end
            prev_en = enable;
        end
    end

    // ---------------- scoreboard / compare ----------------
    always @(negedge clk) begin
        logic [DW-1:0] want;
        if (chk_on) begin
            chk("valid_o", valid_o, exp_valid);
            if (valid_o) pulse_cnt++;
            if (exp_valid) begin
                if (exp_q.size() == 0) begin
                    chk("scoreboard empty", 1'b1, 1'b0);
                end else begin
                    want = exp_q.pop_front();
                    chk("data_o", data_o, want);
                end
            end
            chk("buf_full_o", buf_full_o, mq.size() > FULL_LIMIT);
            chk("count_q", dut.count_q, mq.size());
            chk("error_o", error_o, exp_err);
            chk("state", dut.state_q, exp_state);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input bit en, input bit dv, input logic [IN_W-1:0] d, input bit z);
        @(negedge clk);
        enable       = en;
        data_valid_i = dv;
        data_i       = d;
        zeroize      = z;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [IN_W-1:0] pack4(input int f0, input int f1, input int f2, input int f3);
        logic [IN_W-1:0] w;
        w = '0;
        w[0  +: FIELD_W] = FIELD_W'(f0);
        w[13 +: FIELD_W] = FIELD_W'(f1);
        w[26 +: FIELD_W] = FIELD_W'(f2);
        w[39 +: FIELD_W] = FIELD_W'(f3);
        return w;
    endfunction

    function automatic logic [IN_W-1:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    bit drain_pat [17] = '{1,1,1,1,1,1,0,1,1,1,0,0,1,1,1,1,1};

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int  left;
        int  cyc;
        bit  dv;
        bit  full_prev;

        repeat (3) @(posedge clk);
        #1;
        chk("reset valid_o", valid_o, 1'b0);
        chk("reset data_o", data_o, '0);
        chk("reset buf_full_o", buf_full_o, 1'b0);
        chk("reset error_o", error_o, 1'b0);
        chk("reset count_q", dut.count_q, 0);
        @(negedge clk);
        reset_n = 1'b1;
        chk_on  = 1'b1;

        // Single beat: field0 = 4096, others 0
        tick(1, 1, 64'h0000_0000_0000_1000, 0);
        tick(1, 0, '0, 0);
        chk("single valid_o", valid_o, 1'b1);
        chk("single data_o", data_o, 96'h001000_001000_001000_000000);
        chk("single count_q", dut.count_q, 12);
        tick(0, 0, '0, 0);
        tick(0, 0, '0, 0);

        // Mapping corners: 4097, 0, 8190, 1
        tick(1, 1, pack4(4097, 0, 8190, 1), 0);
        tick(1, 0, '0, 0);
        chk("corner data_o", data_o, 96'h000FFF_7FD003_001000_7FE000);
        chk("corner count_q", dut.count_q, 12);
        tick(0, 0, '0, 0);
        tick(0, 0, '0, 0);

        // Steer count to 116, then drop enable and drain
        foreach (drain_pat[i]) tick(1, drain_pat[i], rnd64(), 0);
        chk("pre-drain count_q", dut.count_q, 116);
        tick(0, 0, '0, 0);
        pulse_cnt = 0;
        repeat (5) tick(0, 0, '0, 0);
        chk("drain pulses", pulse_cnt, 2);
        chk("drain residual", dut.count_q, 12);
        chk("drain valid_o", valid_o, 1'b0);
        tick(1, 0, '0, 0);
        chk("rise clears residual", dut.count_q, 0);
        tick(0, 0, '0, 0);

        // Zeroize at count 100
        repeat (4) tick(1, 1, rnd64(), 0);
        chk("pre-zeroize count_q", dut.count_q, 100);
        tick(1, 1, rnd64(), 1);
        chk("zeroize count_q", dut.count_q, 0);
        chk("zeroize valid_o", valid_o, 1'b0);
        chk("zeroize buf_full_o", buf_full_o, 1'b0);
        tick(0, 0, '0, 0);
        tick(0, 0, '0, 0);

        // Full random key, reads throttled by one-cycle-delayed ~buf_full_o
        pulse_cnt = 0;
        left      = KEY_BEATS;
        cyc       = 0;
        full_prev = 1'b0;
        while (left > 0 && cyc < 5000) begin
            @(negedge clk);
            dv           = !full_prev && ($urandom_range(0, 7) != 0);
            enable       = 1'b1;
            zeroize      = 1'b0;
            data_i       = rnd64();
            data_valid_i = dv;
            full_prev    = buf_full_o;
            if (dv) left--;
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("key beats sent", left, 0);
        repeat (20) tick(0, 0, '0, 0);
        chk("key pulses", pulse_cnt, 512);
        chk("key end count_q", dut.count_q, 0);

        // Encoding error: field 8191
        tick(1, 1, pack4(8191, 5, 0, 0), 0);
        tick(1, 0, '0, 0);
        chk("err data coeff0", data_o[REG_SIZE-1:0], 24'd8376322);
        chk("err set", error_o, ERR_EN);
        repeat (3) tick(1, 0, '0, 0);
        chk("err sticky", error_o, ERR_EN);
        tick(0, 0, '0, 0);
        chk("err held in drain", error_o, ERR_EN);
        tick(1, 0, '0, 0);
        chk("err cleared by rise", error_o, 1'b0);
        tick(0, 0, '0, 0);
        tick(0, 0, '0, 0);

        chk_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
